// File: rtl/cs_resolve_pkg.sv
// Shared types and sizing helpers for the chunked carry-save resolver.
// Optional overflow flag is controlled by the CS_RESOLVE_OVF_EN macro.
package cs_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} cs_state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A one-chunk build still needs a one-bit counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cs_resolve_if.sv
// Operand/result handshake bundle for cs_resolve.
// ovf_o exists only when CS_RESOLVE_OVF_EN is defined.
interface cs_resolve_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_i;
    logic [WIDTH-1:0] carry_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_o;
    logic             cout_o;
`ifdef CS_RESOLVE_OVF_EN
    logic             ovf_o;
`endif

    modport master (
        output in_valid, sum_i, carry_i, out_ready,
        input  in_ready, out_valid, result_o, cout_o
`ifdef CS_RESOLVE_OVF_EN
        , input ovf_o
`endif
    );

    modport slave (
        input  in_valid, sum_i, carry_i, out_ready,
        output in_ready, out_valid, result_o, cout_o
`ifdef CS_RESOLVE_OVF_EN
        , output ovf_o
`endif
    );

endinterface

// File: rtl/cs_resolve_chunk_add.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the caller can form a signed-overflow flag.
module cs_chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic c;

    always_comb begin
        s        = '0;
        c_msb_in = 1'b0;
        c        = cin;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) c_msb_in = c;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/cs_resolve.sv
// Resolves a carry-save (sum, carry) pair to binary, CHUNK bits per cycle.
// Define CS_RESOLVE_OVF_EN to add the signed-overflow output ovf_o.
module cs_resolve
    import cs_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    cs_resolve_if.slave  bus
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_w(NCHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("cs_resolve: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    cs_state_t        state_q, state_d;
    logic [WIDTH-1:0] sum_sh_q, car_sh_q, res_q, res_nxt;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_co;
    logic             in_ready, out_valid, last;

    assign last = (cnt_q == CW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CS_RESOLVE_OVF_EN
    logic chunk_msb_ci;
    logic ovf_q;
`else
    logic unused_c_msb;
`endif

    cs_chunk_add #(.CHUNK(CHUNK)) u_add (
        .a        (sum_sh_q[CHUNK-1:0]),
        .b        (car_sh_q[CHUNK-1:0]),
        .cin      (carry_q),
        .s        (chunk_s),
        .cout     (chunk_co),
`ifdef CS_RESOLVE_OVF_EN
        .c_msb_in (chunk_msb_ci)
`else
        .c_msb_in (unused_c_msb)
`endif
    );

    // Each new chunk enters at the top; after NCHUNK steps chunk 0 sits at bit 0.
    if (NCHUNK > 1) begin : g_res_shift
        assign res_nxt = {chunk_s, res_q[WIDTH-1:CHUNK]};
    end else begin : g_res_single
        assign res_nxt = chunk_s;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum_sh_q <= '0;
            car_sh_q <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
`ifdef CS_RESOLVE_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sum_sh_q <= bus.sum_i;
                        car_sh_q <= bus.carry_i;
                        cnt_q    <= '0;
                        carry_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    res_q    <= res_nxt;
                    sum_sh_q <= sum_sh_q >> CHUNK;
                    car_sh_q <= car_sh_q >> CHUNK;
                    carry_q  <= chunk_co;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last) begin
                        cout_q <= chunk_co;
`ifdef CS_RESOLVE_OVF_EN
                        ovf_q  <= chunk_msb_ci ^ chunk_co;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result_o  = res_q;
    assign bus.cout_o    = cout_q;
`ifdef CS_RESOLVE_OVF_EN
    assign bus.ovf_o     = ovf_q;
`endif

endmodule
